// File: rtl/adder_tree_pkg.sv
// Width helpers and limits shared by the pipelined adder tree and its level slices.
package adder_tree_pkg;

    localparam int unsigned MAX_LEVELS = 8;

    // Word width after k pair-wise add levels; one carry bit per level.
    function automatic int unsigned level_width(input int unsigned width, input int unsigned k);
        return width + k;
    endfunction

    function automatic int unsigned sum_width(input int unsigned width, input int unsigned levels,
                                              input int unsigned acc_len);
        return width + levels + $clog2(acc_len);
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One adder-tree level: PAIRS pair-wise unsigned adds, with an output register and tag stage
// when ADDER_TREE_PIPE_EN is defined, otherwise a purely combinational pass.
module adder_tree_level
    import adder_tree_pkg::*;
#(
    parameter int unsigned IN_W  = 20,
    parameter int unsigned PAIRS = 4
) (
`ifdef ADDER_TREE_PIPE_EN
    input  logic                                          clk,
    input  logic                                          rst,
`endif
    input  logic [2*PAIRS*IN_W-1:0]                       in_data,
    input  logic                                          in_valid,
    input  logic                                          in_clear,
    output logic [PAIRS*level_width(IN_W, 1)-1:0]         out_data,
    output logic                                          out_valid,
    output logic                                          out_clear
);

    localparam int unsigned OUT_W = level_width(IN_W, 1);

    logic [PAIRS*OUT_W-1:0] sum;

    for (genvar p = 0; p < PAIRS; p++) begin : g_pair
        assign sum[p*OUT_W +: OUT_W] = OUT_W'(in_data[2*p*IN_W +: IN_W])
                                     + OUT_W'(in_data[(2*p+1)*IN_W +: IN_W]);
    end

`ifdef ADDER_TREE_PIPE_EN
    logic [PAIRS*OUT_W-1:0] data_q;
    logic                   valid_q;
    logic                   clear_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            data_q  <= sum;
            valid_q <= in_valid;
            clear_q <= in_clear;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_clear = clear_q;
`else
    assign out_data  = sum;
    assign out_valid = in_valid;
    assign out_clear = in_clear;
`endif

endmodule

// File: rtl/pipelined_adder_tree.sv
// Sums 2^LEVELS unsigned words per frame and accumulates ACC_LEN frames per result.
// Define ADDER_TREE_PIPE_EN to register every tree level (latency LEVELS+2, else 2).
module pipelined_adder_tree
    import adder_tree_pkg::*;
#(
    parameter int unsigned WIDTH   = 20,
    parameter int unsigned LEVELS  = 3,
    parameter int unsigned ACC_LEN = 4,
    localparam int unsigned N_IN   = 1 << LEVELS,
    localparam int unsigned SUM_W  = sum_width(WIDTH, LEVELS, ACC_LEN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [N_IN*WIDTH-1:0]  in_data,
    input  logic                   acc_clear,
    output logic                   out_valid,
    output logic [SUM_W-1:0]       out_sum
);

    localparam int unsigned TOP_W = level_width(WIDTH, LEVELS);
    localparam int unsigned CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

    if (LEVELS < 1 || LEVELS > MAX_LEVELS || ACC_LEN < 1) begin : g_bad_cfg
        $error("pipelined_adder_tree: unsupported LEVELS/ACC_LEN");
    end

    logic [N_IN*WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  clear_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            if (in_valid) begin
                data_q <= in_data;
            end
            valid_q <= in_valid;
            clear_q <= acc_clear & in_valid;
        end
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int unsigned IN_W  = level_width(WIDTH, k - 1);
        localparam int unsigned PAIRS = N_IN >> k;

        logic [2*PAIRS*IN_W-1:0]   lvl_in;
        logic                      v_in;
        logic                      c_in;
        logic [PAIRS*(IN_W+1)-1:0] lvl_out;
        logic                      v_out;
        logic                      c_out;

        if (k == 1) begin : g_src
            assign lvl_in = data_q;
            assign v_in   = valid_q;
            assign c_in   = clear_q;
        end else begin : g_src
            assign lvl_in = g_lvl[k-1].lvl_out;
            assign v_in   = g_lvl[k-1].v_out;
            assign c_in   = g_lvl[k-1].c_out;
        end

        adder_tree_level #(
            .IN_W  (IN_W),
            .PAIRS (PAIRS)
        ) u_level (
`ifdef ADDER_TREE_PIPE_EN
            .clk       (clk),
            .rst       (rst),
`endif
            .in_data   (lvl_in),
            .in_valid  (v_in),
            .in_clear  (c_in),
            .out_data  (lvl_out),
            .out_valid (v_out),
            .out_clear (c_out)
        );
    end

    logic [TOP_W-1:0] tree_sum;
    logic             tree_valid;
    logic             tree_clear;

    assign tree_sum   = g_lvl[LEVELS].lvl_out;
    assign tree_valid = g_lvl[LEVELS].v_out;
    assign tree_clear = g_lvl[LEVELS].c_out;

    logic [SUM_W-1:0] acc_q, acc_d;
    logic [SUM_W-1:0] out_sum_q, out_sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_sum_d   = out_sum_q;
        out_valid_d = 1'b0;
        if (tree_valid) begin
            if (tree_clear || cnt_q == '0) begin
                acc_d = SUM_W'(tree_sum);
            end else begin
                acc_d = acc_q + SUM_W'(tree_sum);
            end
            // A clear landing on the group's last slot still closes the group, holding only itself.
            if (cnt_q == CNT_W'(ACC_LEN - 1)) begin
                out_valid_d = 1'b1;
                out_sum_d   = acc_d;
                cnt_d       = '0;
            end else if (tree_clear) begin
                cnt_d = CNT_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_sum_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_sum_q   <= out_sum_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Directed bench for pipelined_adder_tree (20-bit, 3 levels, ACC_LEN 4 and ACC_LEN 1).
module tb_pipelined_adder_tree;

`ifdef ADDER_TREE_PIPE_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 2;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [159:0] in_data;
    logic         acc_clear;
    logic         out_valid;
    logic [24:0]  out_sum;
    logic         out_valid1;
    logic [22:0]  out_sum1;

    pipelined_adder_tree #(.WIDTH(20), .LEVELS(3), .ACC_LEN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .acc_clear (acc_clear),
        .out_valid (out_valid),
        .out_sum   (out_sum)
    );

    pipelined_adder_tree #(.WIDTH(20), .LEVELS(3), .ACC_LEN(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .acc_clear (acc_clear),
        .out_valid (out_valid1),
        .out_sum   (out_sum1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          ov_cyc[$];
    logic [24:0] ov_sum[$];
    int          o1_cyc[$];
    logic [22:0] o1_sum[$];

    always @(negedge clk) begin
        if (out_valid) begin
            ov_cyc.push_back(cyc);
            ov_sum.push_back(out_sum);
        end
        if (out_valid1) begin
            o1_cyc.push_back(cyc);
            o1_sum.push_back(out_sum1);
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] fill(input logic [19:0] v);
        logic [159:0] r;
        for (int i = 0; i < 8; i++) r[i*20 +: 20] = v;
        return r;
    endfunction

    function automatic logic [159:0] ramp(input logic [19:0] b);
        logic [159:0] r;
        for (int i = 0; i < 8; i++) r[i*20 +: 20] = b + 20'(i);
        return r;
    endfunction

    task automatic drive(input logic v, input logic clr, input logic [159:0] d);
        @(negedge clk);
        in_valid  = v;
        acc_clear = clr;
        in_data   = d;
    endtask

    // Idles until the expected pulse has been seen, then checks there was exactly one.
    task automatic wait_and_check(input string name, input int t_exp, input logic [24:0] s_exp);
        while (cyc < t_exp + 2) drive(1'b0, 1'b0, '1);
        chk({name, " pulses"}, ov_cyc.size(), 1);
        if (ov_cyc.size() > 0) begin
            chk({name, " cycle"}, ov_cyc[0], t_exp);
            chk({name, " sum"}, ov_sum[0], s_exp);
        end
        ov_cyc.delete();
        ov_sum.delete();
    endtask

    typedef struct {
        logic [639:0] frames;
        int           gap;
        logic [24:0]  exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int t;
        vecs[0] = '{{fill(20'hFFFFF), fill(20'hFFFFF), fill(20'hFFFFF), fill(20'hFFFFF)},
                    0, 25'h1FFFFE0};
        vecs[1] = '{{ramp(20'd1), ramp(20'd1), ramp(20'd1), ramp(20'd1)}, 0, 25'd144};
        vecs[2] = '{{ramp(20'd1), ramp(20'd1), ramp(20'd1), ramp(20'd1)}, 3, 25'd144};
        vecs[3] = '{{fill(20'd4), fill(20'd3), fill(20'd2), fill(20'd1)}, 1, 25'd80};
        vecs[4] = '{{ramp(20'h80000), ramp(20'h80000), ramp(20'h80000), ramp(20'h80000)},
                    0, 25'h1000070};

        rst = 1'b1; in_valid = 1'b0; acc_clear = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_sum", out_sum, 0);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            for (int j = 0; j < 4; j++) begin
                drive(1'b1, 1'b0, vecs[v].frames[j*160 +: 160]);
                t = cyc;
                for (int g = 0; g < vecs[v].gap; g++) drive(1'b0, 1'b0, '1);
            end
            wait_and_check($sformatf("vec%0d", v), t + LAT, vecs[v].exp);
        end

        drive(1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, '0);
        chk("hold out_valid", out_valid, 0);
        chk("hold out_sum", out_sum, 25'h1000070);

        // Partial group of two frames abandoned by a clear frame.
        drive(1'b1, 1'b0, fill(20'd1));
        drive(1'b1, 1'b0, fill(20'd1));
        drive(1'b1, 1'b1, fill(20'd2));
        drive(1'b1, 1'b0, fill(20'd1));
        drive(1'b1, 1'b0, fill(20'd1));
        drive(1'b1, 1'b0, fill(20'd1));
        t = cyc;
        wait_and_check("mid clear", t + LAT, 25'd40);

        // Clear on the group's closing frame emits that frame alone.
        drive(1'b1, 1'b0, fill(20'd1));
        drive(1'b1, 1'b0, fill(20'd1));
        drive(1'b1, 1'b0, fill(20'd1));
        drive(1'b1, 1'b1, fill(20'd6));
        t = cyc;
        wait_and_check("clear on last", t + LAT, 25'd48);

        // Asynchronous reset with three frames in flight.
        for (int j = 0; j < 3; j++) drive(1'b1, 1'b0, fill(20'd7));
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async rst out_valid", out_valid, 0);
        chk("async rst out_sum", out_sum, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, 1'b0, ramp(20'd1));
            t = cyc;
        end
        wait_and_check("after rst", t + LAT, 25'd144);

        // ACC_LEN = 1 instance: one result per valid frame.
        begin
            int          e_cyc[$];
            logic [22:0] e_sum[$];
            logic [159:0] d;
            logic [31:0]  r;
            logic [22:0]  s;
            o1_cyc.delete();
            o1_sum.delete();
            for (int i = 0; i < 6; i++) begin
                s = '0;
                for (int k = 0; k < 8; k++) begin
                    r = $urandom;
                    d[k*20 +: 20] = r[19:0];
                    s = s + 23'(r[19:0]);
                end
                drive(1'b1, 1'b0, d);
                e_cyc.push_back(cyc + LAT);
                e_sum.push_back(s);
            end
            t = e_cyc[5];
            while (cyc < t + 2) drive(1'b0, 1'b0, '0);
            chk("acc1 pulses", o1_cyc.size(), 6);
            for (int i = 0; i < 6 && i < o1_cyc.size(); i++) begin
                chk($sformatf("acc1 cycle %0d", i), o1_cyc[i], e_cyc[i]);
                chk($sformatf("acc1 sum %0d", i), o1_sum[i], e_sum[i]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipelined_adder_tree.md
# pipelined_adder_tree

Parametrised, fully pipelined unsigned adder tree. It sums 2^LEVELS input words per frame and accumulates ACC_LEN consecutive frames into one result. It is the next generation of the fixed 8-input, 3-level tree, with configurable width, depth and accumulation length, valid tracking, a reset, and frame-aligned accumulator clearing. It sits in the arithmetic benchmark datapath between registered operand sources and a result sink, with no backpressure.

## Interface
- WIDTH, 20: bit width of each input word.
- LEVELS, 3: tree depth; number of inputs N_IN = 2^LEVELS (LEVELS ≥ 1).
- ACC_LEN, 4: frames per accumulated result (≥ 1); ACC_BITS = $clog2(ACC_LEN).
- Derived: SUM_W = WIDTH + LEVELS + ACC_BITS.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  frame present on in_data this cycle.
- in_data  in  N_IN*WIDTH  operand i at bits [i*WIDTH +: WIDTH], unsigned.
- acc_clear  in  1  qualified by in_valid; this frame starts a new accumulation.
- out_valid  out  1  one-cycle pulse; out_sum holds a completed result.
- out_sum  out  SUM_W  sum of ACC_LEN frames, zero-extended.

## Operation
- Stage 0 registers in_data, in_valid and acc_clear on every clock. The data register loads only when in_valid = 1.
- Each tree level k (1..LEVELS) adds adjacent pairs. Level k output width is WIDTH+k. No truncation at any level.
- valid and clear tags travel through a shift pipeline aligned with the data. Bubbles (in_valid = 0) propagate as invalid slots, and the accumulator holds its value on an invalid slot.
- The accumulator (SUM_W bits) and frame counter cnt (0..ACC_LEN-1) update on each valid tree output:
  - If the clear tag is set or cnt == 0: acc ← tree_sum.
  - Otherwise: acc ← acc + tree_sum.
  - If cnt == ACC_LEN-1: out_valid pulses, out_sum ← the new acc value, and cnt ← 0.
  - Otherwise cnt ← cnt+1.
- A clear tag forces cnt to restart at this frame, so the clear frame counts as frame 1. With ACC_LEN = 1, every valid frame produces an output.
- A clear tag arriving on the frame that completes a group (cnt == ACC_LEN-1) emits a result containing only that frame.
- Overflow cannot occur by construction. The maximum result is ACC_LEN·N_IN·(2^WIDTH−1) < 2^SUM_W.
- out_sum holds its value between pulses.

## Timing
- Reset: all valid tags, acc, cnt, out_sum and out_valid are 0. Data registers are also cleared.
- Asserting rst mid-operation discards all in-flight frames and any partial accumulation. The first frame after release is frame 1 of a new group.
- Throughput: one frame per cycle, with no stalls.
- Latency from an in_valid cycle to the corresponding accumulator update:
  - With pipelining: LEVELS+2 cycles (input register, LEVELS level registers, accumulator).
  - Without pipelining: 2 cycles.
- out_valid rises in that same update cycle and lasts exactly one cycle.

## Configuration
- Macro ADDER_TREE_PIPE_EN, defined: a register follows every tree level, giving latency LEVELS+2.
- Undefined: the tree is purely combinational between the stage-0 register and the accumulator, giving latency 2. Tag pipeline depth shrinks accordingly.
- Function is identical in both modes apart from latency.

## Structure
- Package adder_tree_pkg holds:
  - width helpers: function sum_width(WIDTH, LEVELS, ACC_LEN), and level_width(k);
  - constant MAX_LEVELS = 8.
- Sub-module adder_tree_level: one level, parameters IN_W and PAIRS. Pair-wise add, plus a generate-selected output register with valid/clear tag when ADDER_TREE_PIPE_EN is defined.
- The top instantiates LEVELS copies via generate, plus the accumulator/counter logic.

## Test plan
All cases use WIDTH = 20, LEVELS = 3, ACC_LEN = 4, ADDER_TREE_PIPE_EN defined, so latency is 5 and SUM_W = 25.

- **Back-to-back full-scale:** all operands 0xFFFFF, in_valid high for cycles 0–3 → single out_valid at cycle 8, out_sum = 0x1FFFFE0.
- **Operand ordering:** operand i = i+1, 4 frames → out_sum = 4·36 = 144. Repeat with bubbles between frames → same value; out_valid occurs 5 cycles after the 4th valid.
- **Mid-group clear:** frames 1, 1 (operand sum 8 each), then a clear frame of sum 16, then 3 frames of sum 8 → first out_sum = 16+24 = 40, with no output from the abandoned partial.
- **Reset mid-flight:** rst pulsed while 3 frames are in flight → out_valid stays 0. The next 4 frames produce a correct sum with no stale contribution.
- **ACC_LEN = 1, pipelining undefined:** random operands each cycle → out_valid every cycle after 2-cycle latency, and out_sum equals the frame sum.
- **Reset values:** immediately after rst assertion (asynchronous, mid-cycle) → out_valid = 0 and out_sum = 0 before the next clock edge.
